// File: rtl/inference_sequencer.sv
// Front-end controller for the weight/ReLU/argmax pipeline: buffers one input
// vector, replays it as a gap-free indexed burst and queues returned classes.
module inference_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int INPUT_AMOUNT = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           s_value,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [DATA_WIDTH-1:0]           feed_index,
    output logic [DATA_WIDTH-1:0]           feed_value,
    output logic                            feed_enable,
    output logic [DATA_WIDTH:0]             feed_result,
    input  logic [DATA_WIDTH:0]             argmax_result,
    output logic [DATA_WIDTH-1:0]           m_class,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            error
);

    localparam int CNT_W = $clog2(INPUT_AMOUNT);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int IF_W  = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(INPUT_AMOUNT - 1);
    localparam logic [IF_W-1:0]  MAX_CREDIT = IF_W'(MAX_INFLIGHT);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(MAX_INFLIGHT - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_STREAM} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [DATA_WIDTH-1:0]  r_vbuf [INPUT_AMOUNT];
    logic [CNT_W-1:0]       r_load_cnt;
    logic [CNT_W-1:0]       r_stream_cnt;
    logic [CNT_W-1:0]       w_next_cnt;
    logic                   r_feed_enable;
    logic [DATA_WIDTH-1:0]  r_feed_index;
    logic [DATA_WIDTH-1:0]  r_feed_value;
    logic [IF_W-1:0]        r_inflight;
    logic [DATA_WIDTH-1:0]  r_fifo [MAX_INFLIGHT];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [IF_W-1:0]        r_count;
    logic                   r_error;

    logic w_accept, w_last_accept, w_credit, w_stream_entry;
    logic w_pop, w_result_valid, w_push;

    assign w_accept       = s_valid && s_ready;
    assign w_last_accept  = w_accept && (r_load_cnt == LAST_IDX);
    assign w_credit       = r_inflight < MAX_CREDIT;
    assign w_stream_entry = (r_state != ST_STREAM) && (w_next_state == ST_STREAM);
    assign w_pop          = m_valid && m_ready;
    assign w_result_valid = argmax_result[DATA_WIDTH];
    // Results only count against an outstanding vector; the full guard is defensive.
    assign w_push         = w_result_valid && (r_inflight != '0) && ((r_count != MAX_CREDIT) || w_pop);
    assign w_next_cnt     = (r_state == ST_STREAM) ? r_stream_cnt + 1'b1 : '0;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_LOAD;
        else        r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD:   if (w_last_accept) w_next_state = w_credit ? ST_STREAM : ST_WAIT;
            ST_WAIT:   if (w_credit) w_next_state = ST_STREAM;
            ST_STREAM: if (r_stream_cnt == LAST_IDX) w_next_state = ST_LOAD;
            default:   w_next_state = ST_LOAD;
        endcase
    end

    // s_ready is gated by reset so it reads 0 while reset is asserted.
    always_comb begin
        s_ready = rst_n && (r_state == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_load_cnt <= '0;
        else if (w_accept) r_load_cnt <= (r_load_cnt == LAST_IDX) ? '0 : r_load_cnt + 1'b1;
    end

    // NOTE: storage arrays carry no reset; their contents are only read after being written.
    always_ff @(posedge clk) begin
        if (w_accept) r_vbuf[r_load_cnt] <= s_value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stream_cnt  <= '0;
            r_feed_enable <= 1'b0;
            r_feed_index  <= '0;
            r_feed_value  <= '0;
        end else if (w_next_state == ST_STREAM) begin
            r_stream_cnt  <= w_next_cnt;
            r_feed_enable <= 1'b1;
            r_feed_index  <= DATA_WIDTH'(w_next_cnt);
            r_feed_value  <= r_vbuf[w_next_cnt];
        end else begin
            r_stream_cnt  <= '0;
            r_feed_enable <= 1'b0;
            r_feed_index  <= '0;
            r_feed_value  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_stream_entry, w_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= argmax_result[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_result_valid && (r_inflight == '0)) r_error <= 1'b1;
        end
    end

    assign feed_enable = r_feed_enable;
    assign feed_index  = r_feed_index;
    assign feed_value  = r_feed_value;
    assign feed_result = '0;
    assign m_valid     = (r_count != '0);
    assign m_class     = m_valid ? r_fifo[r_rd_ptr] : '0;
    assign inflight    = r_inflight;
    assign error       = r_error;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: load/stream timing, credit stall,
// result FIFO behaviour, spurious results and mid-burst reset.
module tb_inference_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_value;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] feed_index;
    logic [31:0] feed_value;
    logic        feed_enable;
    logic [32:0] feed_result;
    logic [32:0] argmax_result;
    logic [31:0] m_class;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  inflight;
    logic        error;

    int n_asserts = 0;
    int n_fails   = 0;

    inference_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .s_value(s_value), .s_valid(s_valid), .s_ready(s_ready),
        .feed_index(feed_index), .feed_value(feed_value), .feed_enable(feed_enable),
        .feed_result(feed_result), .argmax_result(argmax_result),
        .m_class(m_class), .m_valid(m_valid), .m_ready(m_ready),
        .inflight(inflight), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic reset_dut();
        rst_n = 1'b0; s_valid = 1'b0; s_value = '0; m_ready = 1'b0; argmax_result = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offers four elements base+i*inc; returns at the negedge after the last accept.
    task automatic load_vec(input int base, input int inc, input int gap, input bit pop_on_last);
        for (int i = 0; i < 4; i++) begin
            int budget;
            budget = 0;
            while (!s_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!s_ready) begin
                n_asserts++; n_fails++;
                $display("FAIL load_timeout: s_ready=%b required 1 for element %0d", s_ready, i);
            end
            s_valid = 1'b1;
            s_value = 32'(base + i * inc);
            if (pop_on_last && i == 3) m_ready = 1'b1;
            @(negedge clk);
            if (pop_on_last) m_ready = 1'b0;
            if (gap > 0 && i < 3) begin
                s_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_result(input logic [31:0] cls, input bit pop);
        argmax_result = {1'b1, cls};
        m_ready = pop;
        @(negedge clk);
        argmax_result = '0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_value = '0; m_ready = 1'b0; argmax_result = '0;
        #1;
        n_asserts++; if (s_ready !== 1'b0) begin n_fails++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
        n_asserts++; if (feed_enable !== 1'b0) begin n_fails++; $display("FAIL rst_feed_enable: got %b required 0", feed_enable); end
        n_asserts++; if (feed_index !== 32'd0 || feed_value !== 32'd0) begin n_fails++; $display("FAIL rst_feed_data: got idx=%0d val=%0d required 0/0", feed_index, feed_value); end
        n_asserts++; if (m_valid !== 1'b0 || m_class !== 32'd0) begin n_fails++; $display("FAIL rst_m: got valid=%b class=%0d required 0/0", m_valid, m_class); end
        n_asserts++; if (inflight !== 2'd0 || error !== 1'b0) begin n_fails++; $display("FAIL rst_credit: got inflight=%0d error=%b required 0/0", inflight, error); end
        n_asserts++; if (feed_result !== 33'd0) begin n_fails++; $display("FAIL rst_feed_result: got %h required 0", feed_result); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_asserts++; if (s_ready !== 1'b1) begin n_fails++; $display("FAIL rst_release_s_ready: got %b required 1", s_ready); end
    endtask

    task automatic test_load_stream();
        reset_dut();
        load_vec(1, 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_asserts++; if (feed_enable !== 1'b1 || feed_index !== 32'(k) || feed_value !== 32'd1) begin
                n_fails++; $display("FAIL t1_beat%0d: got en=%b idx=%0d val=%0d required 1/%0d/1", k, feed_enable, feed_index, feed_value, k);
            end
            n_asserts++; if (feed_result !== 33'd0 || s_ready !== 1'b0) begin
                n_fails++; $display("FAIL t1_side%0d: got feed_result=%h s_ready=%b required 0/0", k, feed_result, s_ready);
            end
            @(negedge clk);
        end
        n_asserts++; if (feed_enable !== 1'b0 || s_ready !== 1'b1 || inflight !== 2'd1) begin
            n_fails++; $display("FAIL t1_after: got en=%b s_ready=%b inflight=%0d required 0/1/1", feed_enable, s_ready, inflight);
        end
    endtask

    task automatic test_gapped_load();
        reset_dut();
        load_vec(2, 0, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_asserts++; if (feed_enable !== 1'b1 || feed_index !== 32'(k) || feed_value !== 32'd2 || s_ready !== 1'b0) begin
                n_fails++; $display("FAIL t2_beat%0d: got en=%b idx=%0d val=%0d rdy=%b required 1/%0d/2/0", k, feed_enable, feed_index, feed_value, s_ready, k);
            end
            @(negedge clk);
        end
        n_asserts++; if (feed_enable !== 1'b0 || s_ready !== 1'b1) begin
            n_fails++; $display("FAIL t2_after: got en=%b s_ready=%b required 0/1", feed_enable, s_ready);
        end
    endtask

    task automatic test_credit_wait();
        reset_dut();
        load_vec(1, 0, 0, 1'b0);
        repeat (4) @(negedge clk);
        load_vec(2, 0, 0, 1'b0);
        repeat (4) @(negedge clk);
        load_vec(10, 1, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            n_asserts++; if (s_ready !== 1'b0 || inflight !== 2'd2 || feed_enable !== 1'b0) begin
                n_fails++; $display("FAIL t3_wait%0d: got rdy=%b inflight=%0d en=%b required 0/2/0", c, s_ready, inflight, feed_enable);
            end
            @(negedge clk);
        end
        pulse_result(32'd5, 1'b0);
        n_asserts++; if (m_valid !== 1'b1 || m_class !== 32'd5 || feed_enable !== 1'b0) begin
            n_fails++; $display("FAIL t3_result: got valid=%b class=%0d en=%b required 1/5/0", m_valid, m_class, feed_enable);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_asserts++; if (inflight !== 2'd1 || feed_enable !== 1'b0 || s_ready !== 1'b0) begin
            n_fails++; $display("FAIL t3_pop: got inflight=%0d en=%b rdy=%b required 1/0/0", inflight, feed_enable, s_ready);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_asserts++; if (feed_enable !== 1'b1 || feed_index !== 32'(k) || feed_value !== 32'(10 + k)) begin
                n_fails++; $display("FAIL t3_beat%0d: got en=%b idx=%0d val=%0d required 1/%0d/%0d", k, feed_enable, feed_index, feed_value, k, 10 + k);
            end
            @(negedge clk);
        end
        n_asserts++; if (inflight !== 2'd2 || s_ready !== 1'b1) begin
            n_fails++; $display("FAIL t3_after: got inflight=%0d rdy=%b required 2/1", inflight, s_ready);
        end
    endtask

    task automatic test_result_capture();
        reset_dut();
        load_vec(1, 0, 0, 1'b0);
        repeat (4) @(negedge clk);
        pulse_result(32'd3, 1'b0);
        for (int c = 0; c < 3; c++) begin
            n_asserts++; if (m_valid !== 1'b1 || m_class !== 32'd3) begin
                n_fails++; $display("FAIL t4_hold%0d: got valid=%b class=%0d required 1/3", c, m_valid, m_class);
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_asserts++; if (m_valid !== 1'b0 || inflight !== 2'd0 || error !== 1'b0) begin
            n_fails++; $display("FAIL t4_pop: got valid=%b inflight=%0d error=%b required 0/0/0", m_valid, inflight, error);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        load_vec(1, 0, 0, 1'b0);
        repeat (4) @(negedge clk);
        load_vec(2, 0, 0, 1'b0);
        repeat (4) @(negedge clk);
        pulse_result(32'd4, 1'b0);
        pulse_result(32'd9, 1'b1);
        n_asserts++; if (m_valid !== 1'b1 || m_class !== 32'd9 || inflight !== 2'd1) begin
            n_fails++; $display("FAIL t5_pushpop: got valid=%b class=%0d inflight=%0d required 1/9/1", m_valid, m_class, inflight);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_asserts++; if (m_valid !== 1'b0 || inflight !== 2'd0) begin
            n_fails++; $display("FAIL t5_single_entry: got valid=%b inflight=%0d required 0/0", m_valid, inflight);
        end
        load_vec(3, 0, 0, 1'b0);
        repeat (4) @(negedge clk);
        pulse_result(32'd6, 1'b0);
        load_vec(4, 0, 0, 1'b1);
        n_asserts++; if (inflight !== 2'd1 || m_valid !== 1'b0 || feed_enable !== 1'b1 || feed_value !== 32'd4) begin
            n_fails++; $display("FAIL t5_pop_entry: got inflight=%0d valid=%b en=%b val=%0d required 1/0/1/4", inflight, m_valid, feed_enable, feed_value);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_error_and_reset();
        reset_dut();
        @(negedge clk);
        pulse_result(32'd7, 1'b0);
        n_asserts++; if (error !== 1'b1 || m_valid !== 1'b0 || inflight !== 2'd0) begin
            n_fails++; $display("FAIL t6_spurious: got error=%b valid=%b inflight=%0d required 1/0/0", error, m_valid, inflight);
        end
        repeat (2) @(negedge clk);
        n_asserts++; if (error !== 1'b1) begin n_fails++; $display("FAIL t6_sticky: got error=%b required 1", error); end
        load_vec(5, 1, 0, 1'b0);
        repeat (2) @(negedge clk);
        n_asserts++; if (feed_enable !== 1'b1 || feed_index !== 32'd2 || feed_value !== 32'd7) begin
            n_fails++; $display("FAIL t6_beat2: got en=%b idx=%0d val=%0d required 1/2/7", feed_enable, feed_index, feed_value);
        end
        rst_n = 1'b0;
        #1;
        n_asserts++; if (feed_enable !== 1'b0 || error !== 1'b0 || s_ready !== 1'b0 || inflight !== 2'd0) begin
            n_fails++; $display("FAIL t6_async_rst: got en=%b error=%b rdy=%b inflight=%0d required 0/0/0/0", feed_enable, error, s_ready, inflight);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_asserts++; if (s_ready !== 1'b1 || inflight !== 2'd0) begin
            n_fails++; $display("FAIL t6_release: got rdy=%b inflight=%0d required 1/0", s_ready, inflight);
        end
        @(negedge clk);
        n_asserts++; if (feed_enable !== 1'b0 || feed_index !== 32'd0 || error !== 1'b0) begin
            n_fails++; $display("FAIL t6_no_resume: got en=%b idx=%0d error=%b required 0/0/0", feed_enable, feed_index, error);
        end
    endtask

    initial begin
        test_reset();
        test_load_stream();
        test_gapped_load();
        test_credit_wait();
        test_result_capture();
        test_back_to_back();
        test_error_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
